// File: rtl/apb3_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : apb3_master_bridge
//  Description : Single-outstanding command/response to APB3 master bridge
//                with byte strobes and an optional ACCESS-phase timeout.
//  Revision    : 1.0 - initial release
// ============================================================================

module apb3_master_bridge #(
  parameter int ADDR_W      = 12,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  // command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_strb,
  // response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  // APB3 master
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [31:0]       PWDATA,
  output logic [3:0]        PSTRB,
  input  logic [31:0]       PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int c_CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_wait_cnt;
  logic [c_CNT_W-1:0] w_cnt_inc;
  logic               w_accept;
  logic               w_xfer_done;
  logic               w_abort;

  assign cmd_ready = (r_state == S_IDLE);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_xfer_done = 1'b0;
    w_abort     = 1'b0;
    // Saturating increment keeps the counter from wrapping when the timeout is disabled
    w_cnt_inc   = (r_wait_cnt == c_CNT_MAX) ? r_wait_cnt : r_wait_cnt + 1'b1;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (PSEL && PENABLE && PREADY) begin
          w_xfer_done = 1'b1;
          w_state_nxt = S_RESP;
        end else if ((TIMEOUT_CYC > 0) && (w_cnt_inc == c_TIMEOUT)) begin
          w_abort     = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= '0;
      r_wait_cnt  <= '0;
    end else begin
      if (w_accept) begin
        PSEL       <= 1'b1;
        PADDR      <= cmd_addr;
        PWRITE     <= cmd_write;
        PSTRB      <= cmd_write ? cmd_strb : 4'h0;
        r_wait_cnt <= '0;
        // Reads leave the write-data bus untouched
        if (cmd_write) begin
          PWDATA <= cmd_wdata;
        end
      end
      if (r_state == S_SETUP) begin
        PENABLE <= 1'b1;
      end
      if ((r_state == S_ACCESS) && !w_xfer_done) begin
        r_wait_cnt <= w_cnt_inc;
      end
      if (w_xfer_done || w_abort) begin
        PSEL        <= 1'b0;
        PENABLE     <= 1'b0;
        rsp_valid   <= 1'b1;
        rsp_rdata   <= (w_abort || PWRITE) ? 32'h0 : PRDATA;
        rsp_err     <= w_abort ? 1'b1 : PSLVERR;
        rsp_timeout <= w_abort;
      end
      if ((r_state == S_RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb3_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb3_master_bridge
//  Description : Directed self-checking bench for apb3_master_bridge.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_apb3_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [11:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          m_psel_n;
  int          m_pen_n;
  int          m_lat;
  logic        m_proto_ok;
  logic [31:0] m_last_wd;

  apb3_master_bridge #(
    .ADDR_W      (12),
    .TIMEOUT_CYC (16)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PADDR       (PADDR),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .PSTRB       (PSTRB),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and act as the slave; returns at the first negedge showing rsp_valid.
  task automatic xfer(input string tag, input logic wr, input logic [11:0] addr,
                      input logic [31:0] wd, input logic [3:0] st, input int waits,
                      input logic [31:0] rd, input logic err);
    int k = 0;
    chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
    PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = 32'hFFFF_FFFF;
    m_psel_n = 0; m_pen_n = 0; m_lat = 0; m_proto_ok = 1'b1;
    while (m_lat < 60) begin
      @(negedge PCLK);
      m_lat++;
      if (m_lat == 1) begin
        cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = ~wd; cmd_strb = ~st;
        if (!(PSEL && !PENABLE)) m_proto_ok = 1'b0;
      end
      if (rsp_valid) break;
      if (PSEL) m_psel_n++;
      if (PENABLE) m_pen_n++;
      if (PENABLE && !PSEL) m_proto_ok = 1'b0;
      if (PSEL && (PADDR !== addr || PWRITE !== wr || PSTRB !== (wr ? st : 4'h0) ||
                   PWDATA !== (wr ? wd : m_last_wd)))
        m_proto_ok = 1'b0;
      if (PSEL && PENABLE) begin
        k++;
        PREADY  = (k > waits);
        PSLVERR = (k > waits) ? err : 1'b1;
        PRDATA  = (k > waits) ? rd : 32'hFFFF_FFFF;
      end else begin
        PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = 32'hFFFF_FFFF;
      end
    end
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;
    if (wr) m_last_wd = wd;
    chk({tag, ".proto"}, 32'(m_proto_ok), 32'd1);
  endtask

  // Hold rsp_ready low for 'hold' cycles checking stability, then consume the response.
  task automatic rsp_take(input string tag, input int hold, input logic [31:0] rd,
                          input logic err, input logic to);
    for (int i = 0; i <= hold; i++) begin
      chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, ".rsp_rdata"}, rsp_rdata, rd);
      chk({tag, ".rsp_err"}, 32'(rsp_err), 32'(err));
      chk({tag, ".rsp_timeout"}, 32'(rsp_timeout), 32'(to));
      chk({tag, ".cmd_ready_resp"}, 32'(cmd_ready), 32'd0);
      if (i < hold) @(negedge PCLK);
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    chk({tag, ".rsp_valid_clr"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
    chk({tag, ".psel_idle"}, 32'(PSEL), 32'd0);
  endtask

  initial begin
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 12'h0;
    cmd_wdata = 32'h0; cmd_strb = 4'h0; rsp_ready = 1'b0;
    PRDATA = 32'h0; PREADY = 1'b0; PSLVERR = 1'b0; m_last_wd = 32'h0;
    repeat (2) @(negedge PCLK);

    // Reset state
    chk("rst.psel", 32'(PSEL), 32'd0);
    chk("rst.penable", 32'(PENABLE), 32'd0);
    chk("rst.pwrite", 32'(PWRITE), 32'd0);
    chk("rst.paddr", 32'(PADDR), 32'd0);
    chk("rst.pwdata", PWDATA, 32'd0);
    chk("rst.pstrb", 32'(PSTRB), 32'd0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_err", 32'(rsp_err), 32'd0);
    chk("rst.rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("rst.rsp_rdata", rsp_rdata, 32'd0);
    chk("rst.cmd_ready", 32'(cmd_ready), 32'd1);
    PRESET = 1'b0;
    @(negedge PCLK);

    // Zero-wait full-strobe write
    xfer("wr0", 1'b1, 12'h000, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0);
    chk("wr0.psel_cycles", 32'(m_psel_n), 32'd2);
    chk("wr0.penable_cycles", 32'(m_pen_n), 32'd1);
    chk("wr0.latency", 32'(m_lat), 32'd3);
    rsp_take("wr0", 0, 32'h0, 1'b0, 1'b0);

    // Read with 3 wait states; PSLVERR noise while PREADY low must be ignored
    xfer("rd4", 1'b0, 12'h004, 32'h0, 4'hF, 3, 32'hA5A5_5A5A, 1'b0);
    chk("rd4.psel_cycles", 32'(m_psel_n), 32'd5);
    chk("rd4.penable_cycles", 32'(m_pen_n), 32'd4);
    chk("rd4.latency", 32'(m_lat), 32'd6);
    rsp_take("rd4", 0, 32'hA5A5_5A5A, 1'b0, 1'b0);

    // Masked write
    xfer("wrm", 1'b1, 12'h000, 32'h1234_5678, 4'h3, 0, 32'h0, 1'b0);
    chk("wrm.psel_cycles", 32'(m_psel_n), 32'd2);
    chk("wrm.penable_cycles", 32'(m_pen_n), 32'd1);
    chk("wrm.latency", 32'(m_lat), 32'd3);
    rsp_take("wrm", 0, 32'h0, 1'b0, 1'b0);

    // Slave never ready: abort after 16 ACCESS cycles
    xfer("tmo", 1'b0, 12'h008, 32'h0, 4'h0, 1000, 32'h0, 1'b0);
    chk("tmo.psel_cycles", 32'(m_psel_n), 32'd17);
    chk("tmo.penable_cycles", 32'(m_pen_n), 32'd16);
    chk("tmo.latency", 32'(m_lat), 32'd18);
    rsp_take("tmo", 0, 32'h0, 1'b1, 1'b1);

    // Slave error on write; response back-pressured with a pending command
    xfer("err", 1'b1, 12'h00C, 32'hCAFE_F00D, 4'hF, 0, 32'h0, 1'b1);
    chk("err.latency", 32'(m_lat), 32'd3);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h0FF;
    cmd_wdata = 32'h5555_5555; cmd_strb = 4'h1;
    rsp_take("err", 5, 32'h0, 1'b1, 1'b0);
    chk("err.pwdata_kept", PWDATA, 32'hCAFE_F00D);

    // Reset in the second ACCESS wait cycle
    chk("rst2.cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h020; cmd_strb = 4'h0;
    PREADY = 1'b0; PSLVERR = 1'b0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("rst2.in_access", 32'(PENABLE), 32'd1);
    PRESET = 1'b1;
    @(negedge PCLK);
    chk("rst2.psel", 32'(PSEL), 32'd0);
    chk("rst2.penable", 32'(PENABLE), 32'd0);
    chk("rst2.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst2.cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst2.pwdata", PWDATA, 32'd0);
    PRESET = 1'b0;
    m_last_wd = 32'h0;
    repeat (3) @(negedge PCLK);
    chk("rst2.no_rsp", 32'(rsp_valid), 32'd0);

    // Normal read after the aborted transfer
    xfer("rd10", 1'b0, 12'h010, 32'h0, 4'h0, 1, 32'h0BAD_F00D, 1'b0);
    chk("rd10.psel_cycles", 32'(m_psel_n), 32'd3);
    chk("rd10.penable_cycles", 32'(m_pen_n), 32'd2);
    chk("rd10.latency", 32'(m_lat), 32'd4);
    rsp_take("rd10", 0, 32'h0BAD_F00D, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/apb3_master_bridge.md
APB3_MASTER_BRIDGE -- requirements
Module: apb3_master_bridge

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, meaning the PADDR width.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 16, meaning the maximum number of ACCESS cycles with PREADY low before abort; 0 disables the timeout.
REQ-003 Port PCLK, input, 1, SHALL be the single clock; all logic is rising-edge.
REQ-004 Port PRESET, input, 1, SHALL be the reset: synchronous and active-high.
REQ-005 Port cmd_valid, input, 1: command request.
REQ-006 Port cmd_ready, output, 1: block can accept a command.
REQ-007 Port cmd_write, input, 1: 1 = write, 0 = read.
REQ-008 Port cmd_addr, input, ADDR_W: target address.
REQ-009 Port cmd_wdata, input, 32: write data.
REQ-010 Port cmd_strb, input, 4: byte strobes for writes.
REQ-011 Port rsp_valid, output, 1: response available.
REQ-012 Port rsp_ready, input, 1: response consumed.
REQ-013 Port rsp_rdata, output, 32: read data; 0 for writes.
REQ-014 Port rsp_err, output, 1: PSLVERR seen, or timeout.
REQ-015 Port rsp_timeout, output, 1: the transfer was aborted by timeout.
REQ-016 Ports PADDR (ADDR_W), PSEL, PENABLE, PWRITE, PWDATA (32) and PSTRB (4) SHALL be outputs, and PRDATA (32), PREADY and PSLVERR SHALL be inputs, all per APB3 with strobes.

Function
REQ-017 The block SHALL implement FSM states IDLE, SETUP, ACCESS and RESP, and every APB output SHALL be driven from a register.
REQ-018 cmd_ready SHALL be 1 only in IDLE, and a command SHALL be accepted on an edge where cmd_valid && cmd_ready.
REQ-019 On acceptance the block SHALL latch addr, write, wdata and strb, and go to SETUP.
REQ-020 SETUP SHALL drive PSEL=1 and PENABLE=0, hold PADDR, PWRITE, PWDATA and PSTRB stable, and move to ACCESS after exactly 1 cycle.
REQ-021 ACCESS SHALL drive PSEL=1 and PENABLE=1, and all other APB outputs SHALL be unchanged from SETUP.
REQ-022 In ACCESS with PREADY=1, the block SHALL capture PRDATA for reads (0 for writes) and PSLVERR into rsp_err, set rsp_timeout=0, drop PSEL and PENABLE on the same edge, and go to RESP.
REQ-023 In ACCESS with PREADY=0, the block SHALL increment a wait counter and remain in ACCESS.
REQ-024 If TIMEOUT_CYC>0 and the wait counter reaches TIMEOUT_CYC, the block SHALL abort: PSEL and PENABLE go to 0, rsp_err=1, rsp_timeout=1, rsp_rdata=0, and the state goes to RESP.
REQ-025 PSLVERR SHALL be sampled only when PSEL && PENABLE && PREADY, and ignored otherwise.
REQ-026 For reads, PSTRB SHALL be driven 0 and PWDATA SHALL hold its previous value.
REQ-027 The wait counter SHALL be wide enough to hold TIMEOUT_CYC without wrap, SHALL clear on entry to SETUP, and SHALL saturate when TIMEOUT_CYC=0.
REQ-028 RESP SHALL hold rsp_valid=1 and the response fields stable until rsp_ready=1, then go to IDLE.
REQ-029 The block SHALL accept no new command in RESP; cmd_valid asserted early SHALL be held by the requester.
REQ-030 Latency: with command accepted at edge N and PREADY=1 in the first ACCESS cycle, PSEL SHALL rise after edge N, PENABLE after N+1, and rsp_valid after N+2; minimum spacing between two commands is 4 cycles (rsp_ready held 1).
REQ-031 Whenever PSEL=0, PENABLE SHALL be 0; PENABLE SHALL never be 1 in the first cycle of a transfer.
REQ-032 Changes on cmd_* after acceptance SHALL not affect the transfer in flight.

Reset
REQ-033 When PRESET=1 at an edge, the state SHALL go to IDLE, and PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, rsp_err, rsp_timeout, rsp_rdata and the wait counter SHALL all be 0; cmd_ready SHALL be 1 after that edge.
REQ-034 Reset during SETUP, ACCESS or RESP SHALL abort the transfer at once with no response issued, and PSEL SHALL be 0 after the reset edge.

Verification
REQ-035 The bench SHALL cover: write addr 0x000, data 0xDEADBEEF, strb 0xF, zero-wait slave -> PSEL high 2 cycles, PENABLE high 1 cycle, PSTRB=0xF, rsp_valid after 3 edges, rsp_err=0.
REQ-036 The bench SHALL cover: read 0x004, slave PRDATA=0xA5A55A5A, 3 wait states -> PENABLE high 4 cycles, rsp_rdata=0xA5A55A5A, PSTRB=0 throughout.
REQ-037 The bench SHALL cover: masked write 0x000, data 0x12345678, strb 0x3 -> PSTRB=0x3 stable across SETUP and ACCESS.
REQ-038 The bench SHALL cover: PREADY held 0, TIMEOUT_CYC=16 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-039 The bench SHALL cover: PSLVERR=1 with PREADY=1 on a write -> rsp_err=1, rsp_timeout=0; rsp_ready held 0 for 5 cycles -> rsp_valid and the fields stay stable, cmd_ready=0.
REQ-040 The bench SHALL cover: PRESET asserted in the second ACCESS wait cycle -> PSEL=0 and PENABLE=0 next cycle, no rsp_valid, next command completes normally.
